// File: rtl/vdp_port_ctrl.sv
// CPU-side VDP port controller: command latch, auto-incrementing VRAM address, read-ahead buffer.
// Define GG_CRAM_EN for the Game Gear 12-bit palette (two data writes per CRAM entry).
module vdp_port_ctrl #(
  parameter int ADDR_W  = 14,
  parameter int CRAM_AW = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ctrl_wr,
  input  logic               data_wr,
  input  logic               ctrl_rd,
  input  logic               data_rd,
  input  logic [7:0]         cpu_din,
  output logic [7:0]         cpu_dout,
  output logic               busy,
  output logic               vram_we,
  output logic               vram_re,
  output logic [ADDR_W-1:0]  vram_addr,
  output logic [7:0]         vram_din,
  input  logic [7:0]         vram_dout,
  output logic               cram_we,
  output logic [CRAM_AW-1:0] cram_addr,
`ifdef GG_CRAM_EN
  output logic [11:0]        cram_din,
`else
  output logic [7:0]         cram_din,
`endif
  output logic               reg_we,
  output logic [3:0]         reg_num,
  output logic [7:0]         reg_data,
  output logic               status_rd
);

`ifdef GG_CRAM_EN
  localparam int CRAM_DW = 12;
`else
  localparam int CRAM_DW = 8;
`endif

  typedef enum logic {LATCH_FIRST, LATCH_SECOND} latch_e;
  typedef enum logic [1:0] {RA_IDLE, RA_ISSUE, RA_WAIT} ra_e;

  latch_e               latch_q, latch_d;
  ra_e                  ra_q, ra_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [1:0]           code_q, code_d;
  logic [7:0]           rd_buf_q, rd_buf_d;
  logic                 vram_we_q, vram_we_d;
  logic [ADDR_W-1:0]    vram_addr_q, vram_addr_d;
  logic [7:0]           vram_din_q, vram_din_d;
  logic                 cram_we_q, cram_we_d;
  logic [CRAM_AW-1:0]   cram_addr_q, cram_addr_d;
  logic [CRAM_DW-1:0]   cram_din_q, cram_din_d;
  logic                 reg_we_q, reg_we_d;
  logic [3:0]           reg_num_q, reg_num_d;
  logic [7:0]           reg_data_q, reg_data_d;
  logic                 status_rd_q, status_rd_d;
  logic                 start_fetch;
  logic                 busy_w;
`ifdef GG_CRAM_EN
  logic [7:0]           cram_lo_q, cram_lo_d;
`endif

  assign busy_w = (ra_q != RA_IDLE);

  always_comb begin
    latch_d     = latch_q;
    ra_d        = ra_q;
    addr_d      = addr_q;
    code_d      = code_q;
    rd_buf_d    = rd_buf_q;
    vram_we_d   = 1'b0;
    vram_addr_d = vram_addr_q;
    vram_din_d  = vram_din_q;
    cram_we_d   = 1'b0;
    cram_addr_d = cram_addr_q;
    cram_din_d  = cram_din_q;
    reg_we_d    = 1'b0;
    reg_num_d   = reg_num_q;
    reg_data_d  = reg_data_q;
    status_rd_d = 1'b0;
    start_fetch = 1'b0;
`ifdef GG_CRAM_EN
    cram_lo_d   = cram_lo_q;
`endif

    // Read-ahead: address presented in ISSUE, data returns during WAIT.
    case (ra_q)
      RA_ISSUE: ra_d = RA_WAIT;
      RA_WAIT: begin
        ra_d     = RA_IDLE;
        rd_buf_d = vram_dout;
        addr_d   = addr_q + ADDR_W'(1);
      end
      default: ;
    endcase

    if (ctrl_wr) begin
      if (latch_q == LATCH_FIRST) begin
        addr_d  = {addr_q[ADDR_W-1:8], cpu_din};
        latch_d = LATCH_SECOND;
      end else begin
        addr_d  = {cpu_din[ADDR_W-9:0], addr_q[7:0]};
        code_d  = cpu_din[7:6];
        latch_d = LATCH_FIRST;
        case (cpu_din[7:6])
          2'd0: start_fetch = 1'b1;
          2'd2: begin
            reg_we_d   = 1'b1;
            reg_num_d  = cpu_din[3:0];
            reg_data_d = addr_q[7:0];
          end
          default: ;
        endcase
      end
    end else if (data_wr) begin
      if (!busy_w) begin
        latch_d  = LATCH_FIRST;
        rd_buf_d = cpu_din;
        addr_d   = addr_q + ADDR_W'(1);
        if (code_q == 2'd3) begin
`ifdef GG_CRAM_EN
          // Even byte is held until its odd partner completes the 12-bit entry.
          if (!addr_q[0]) begin
            cram_lo_d = cpu_din;
          end else begin
            cram_we_d   = 1'b1;
            cram_addr_d = addr_q[CRAM_AW:1];
            cram_din_d  = {cpu_din[3:0], cram_lo_q};
          end
`else
          cram_we_d   = 1'b1;
          cram_addr_d = addr_q[CRAM_AW-1:0];
          cram_din_d  = cpu_din;
`endif
        end else begin
          vram_we_d   = 1'b1;
          vram_addr_d = addr_q;
          vram_din_d  = cpu_din;
        end
      end
    end else if (data_rd) begin
      if (!busy_w) begin
        latch_d     = LATCH_FIRST;
        start_fetch = 1'b1;
      end
    end else if (ctrl_rd) begin
      latch_d     = LATCH_FIRST;
      status_rd_d = 1'b1;
    end

    // A fetch started by a second control byte uses the freshly written address.
    if (start_fetch && (ra_q == RA_IDLE)) begin
      ra_d        = RA_ISSUE;
      vram_addr_d = addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      latch_q     <= LATCH_FIRST;
      ra_q        <= RA_IDLE;
      addr_q      <= '0;
      code_q      <= '0;
      rd_buf_q    <= '0;
      vram_we_q   <= 1'b0;
      vram_addr_q <= '0;
      vram_din_q  <= '0;
      cram_we_q   <= 1'b0;
      cram_addr_q <= '0;
      cram_din_q  <= '0;
      reg_we_q    <= 1'b0;
      reg_num_q   <= '0;
      reg_data_q  <= '0;
      status_rd_q <= 1'b0;
`ifdef GG_CRAM_EN
      cram_lo_q   <= '0;
`endif
    end else begin
      latch_q     <= latch_d;
      ra_q        <= ra_d;
      addr_q      <= addr_d;
      code_q      <= code_d;
      rd_buf_q    <= rd_buf_d;
      vram_we_q   <= vram_we_d;
      vram_addr_q <= vram_addr_d;
      vram_din_q  <= vram_din_d;
      cram_we_q   <= cram_we_d;
      cram_addr_q <= cram_addr_d;
      cram_din_q  <= cram_din_d;
      reg_we_q    <= reg_we_d;
      reg_num_q   <= reg_num_d;
      reg_data_q  <= reg_data_d;
      status_rd_q <= status_rd_d;
`ifdef GG_CRAM_EN
      cram_lo_q   <= cram_lo_d;
`endif
    end
  end

  assign cpu_dout  = rd_buf_q;
  assign busy      = busy_w;
  assign vram_we   = vram_we_q;
  assign vram_re   = (ra_q == RA_ISSUE);
  assign vram_addr = vram_addr_q;
  assign vram_din  = vram_din_q;
  assign cram_we   = cram_we_q;
  assign cram_addr = cram_addr_q;
  assign cram_din  = cram_din_q;
  assign reg_we    = reg_we_q;
  assign reg_num   = reg_num_q;
  assign reg_data  = reg_data_q;
  assign status_rd = status_rd_q;

endmodule

// File: tb/tb_vdp_port_ctrl.sv
// Bench for vdp_port_ctrl: directed scenarios plus random port traffic against a byte-level model.
module tb_vdp_port_ctrl;
`ifdef GG_CRAM_EN
  localparam int CDW = 12;
`else
  localparam int CDW = 8;
`endif
  localparam int K_CW = 0, K_DW = 1, K_DR = 2, K_CR = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           ctrl_wr = 1'b0, data_wr = 1'b0, ctrl_rd = 1'b0, data_rd = 1'b0;
  logic [7:0]     cpu_din = 8'h00;
  logic [7:0]     cpu_dout;
  logic           busy, vram_we, vram_re;
  logic [13:0]    vram_addr;
  logic [7:0]     vram_din;
  logic [7:0]     vram_dout;
  logic           cram_we;
  logic [4:0]     cram_addr;
  logic [CDW-1:0] cram_din;
  logic           reg_we;
  logic [3:0]     reg_num;
  logic [7:0]     reg_data;
  logic           status_rd;

  int n_vec = 0;
  int n_err = 0;

  vdp_port_ctrl dut (
    .clk(clk), .reset(reset), .ctrl_wr(ctrl_wr), .data_wr(data_wr), .ctrl_rd(ctrl_rd),
    .data_rd(data_rd), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .busy(busy),
    .vram_we(vram_we), .vram_re(vram_re), .vram_addr(vram_addr), .vram_din(vram_din),
    .vram_dout(vram_dout), .cram_we(cram_we), .cram_addr(cram_addr), .cram_din(cram_din),
    .reg_we(reg_we), .reg_num(reg_num), .reg_data(reg_data), .status_rd(status_rd)
  );

  always #5 clk = ~clk;

  // VRAM port A environment, with a preload path for directed data.
  logic [7:0]  vram_mem [0:16383];
  logic        fill_req = 1'b0, pre_we = 1'b0;
  logic [13:0] pre_addr = 14'h0;
  logic [7:0]  pre_data = 8'h0;

  function automatic logic [7:0] fill_val(input int i);
    return 8'((i * 37 + 11) ^ (i >> 3));
  endfunction

  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < 16384; i++) vram_mem[i] <= fill_val(i);
    end else if (pre_we) begin
      vram_mem[pre_addr] <= pre_data;
    end else if (vram_we) begin
      vram_mem[vram_addr] <= vram_din;
    end
    if (vram_re) vram_dout <= vram_mem[vram_addr];
  end

  function automatic logic [31:0] ev_vw(input logic [13:0] a, input logic [7:0] v);
    return {4'h1, 6'h0, a, v};
  endfunction
  function automatic logic [31:0] ev_cw(input logic [4:0] a, input logic [11:0] v);
    return {4'h2, 11'h0, a, v};
  endfunction
  function automatic logic [31:0] ev_rw(input logic [3:0] n, input logic [7:0] v);
    return {4'h3, 16'h0, n, v};
  endfunction
  function automatic logic [31:0] ev_re(input logic [13:0] a);
    return {4'h4, 10'h0, a, 4'h0};
  endfunction
  function automatic logic [31:0] ev_st();
    return 32'h5000_0000;
  endfunction

  logic [31:0] obs_q[$];
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    if (vram_we)   obs_q.push_back(ev_vw(vram_addr, vram_din));
    if (cram_we)   obs_q.push_back(ev_cw(cram_addr, 12'(cram_din)));
    if (reg_we)    obs_q.push_back(ev_rw(reg_num, reg_data));
    if (vram_re)   obs_q.push_back(ev_re(vram_addr));
    if (status_rd) obs_q.push_back(ev_st());
  end

  // Reference model of the CPU-visible port behaviour.
  logic [7:0]  ref_mem [0:16383];
  logic [13:0] ref_addr;
  logic [1:0]  ref_code;
  bit          ref_first;
  logic [7:0]  ref_buf;
  logic [7:0]  ref_lo;

  task automatic model_fetch();
    exp_q.push_back(ev_re(ref_addr));
    ref_buf  = ref_mem[ref_addr];
    ref_addr = ref_addr + 14'd1;
  endtask

  task automatic model_apply(input int kind, input logic [7:0] d);
    case (kind)
      K_CW: begin
        if (ref_first) begin
          ref_addr[7:0] = d;
          ref_first = 1'b0;
        end else begin
          ref_addr[13:8] = d[5:0];
          ref_code = d[7:6];
          ref_first = 1'b1;
          if (ref_code == 2'd0) model_fetch();
          else if (ref_code == 2'd2) exp_q.push_back(ev_rw(d[3:0], ref_addr[7:0]));
        end
      end
      K_DW: begin
        ref_first = 1'b1;
        if (ref_code == 2'd3) begin
`ifdef GG_CRAM_EN
          if (ref_addr[0] == 1'b0) ref_lo = d;
          else exp_q.push_back(ev_cw(ref_addr[5:1], {d[3:0], ref_lo}));
`else
          exp_q.push_back(ev_cw(ref_addr[4:0], {4'h0, d}));
`endif
        end else begin
          exp_q.push_back(ev_vw(ref_addr, d));
          ref_mem[ref_addr] = d;
        end
        ref_buf  = d;
        ref_addr = ref_addr + 14'd1;
      end
      K_DR: begin
        ref_first = 1'b1;
        model_fetch();
      end
      default: begin
        ref_first = 1'b1;
        exp_q.push_back(ev_st());
      end
    endcase
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ctrl_wr = 1'b0; data_wr = 1'b0; data_rd = 1'b0; ctrl_rd = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    ref_addr = '0; ref_code = '0; ref_first = 1'b1; ref_buf = '0; ref_lo = '0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic poke(input logic [13:0] a, input logic [7:0] v);
    @(posedge clk); #1;
    pre_we = 1'b1; pre_addr = a; pre_data = v;
    @(posedge clk); #1;
    pre_we = 1'b0;
    ref_mem[a] = v;
  endtask

  // One strobe, then enough idle cycles for any read-ahead to finish.
  task automatic op(input int kind, input logic [7:0] d);
    @(posedge clk); #1;
    cpu_din = d;
    case (kind)
      K_CW: ctrl_wr = 1'b1;
      K_DW: data_wr = 1'b1;
      K_DR: data_rd = 1'b1;
      default: ctrl_rd = 1'b1;
    endcase
    @(posedge clk); #1;
    ctrl_wr = 1'b0; data_wr = 1'b0; data_rd = 1'b0; ctrl_rd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_apply(kind, d);
  endtask

  task automatic test_reset();
    do_reset();
    n_vec += 13;
    if (cpu_dout !== 8'h00)   begin n_err++; $display("FAIL reset_cpu_dout: got %h want 00", cpu_dout); end
    if (busy !== 1'b0)        begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (vram_we !== 1'b0)     begin n_err++; $display("FAIL reset_vram_we: got %b want 0", vram_we); end
    if (vram_re !== 1'b0)     begin n_err++; $display("FAIL reset_vram_re: got %b want 0", vram_re); end
    if (vram_addr !== 14'h0)  begin n_err++; $display("FAIL reset_vram_addr: got %h want 0", vram_addr); end
    if (vram_din !== 8'h0)    begin n_err++; $display("FAIL reset_vram_din: got %h want 0", vram_din); end
    if (cram_we !== 1'b0)     begin n_err++; $display("FAIL reset_cram_we: got %b want 0", cram_we); end
    if (cram_addr !== 5'h0)   begin n_err++; $display("FAIL reset_cram_addr: got %h want 0", cram_addr); end
    if (cram_din !== '0)      begin n_err++; $display("FAIL reset_cram_din: got %h want 0", cram_din); end
    if (reg_we !== 1'b0)      begin n_err++; $display("FAIL reset_reg_we: got %b want 0", reg_we); end
    if (reg_num !== 4'h0)     begin n_err++; $display("FAIL reset_reg_num: got %h want 0", reg_num); end
    if (reg_data !== 8'h0)    begin n_err++; $display("FAIL reset_reg_data: got %h want 0", reg_data); end
    if (status_rd !== 1'b0)   begin n_err++; $display("FAIL reset_status_rd: got %b want 0", status_rd); end
  endtask

  task automatic test_vram_write();
    do_reset();
    op(K_CW, 8'h00); op(K_CW, 8'h40); op(K_DW, 8'hAA); op(K_DW, 8'h55);
    n_vec++;
    if (obs_q.size() != 2) begin
      n_err++; $display("FAIL vram_write_count: got %0d want 2", obs_q.size());
    end else begin
      n_vec += 2;
      if (obs_q[0] !== ev_vw(14'h0000, 8'hAA)) begin n_err++; $display("FAIL vram_write_0: got %h want %h", obs_q[0], ev_vw(14'h0000, 8'hAA)); end
      if (obs_q[1] !== ev_vw(14'h0001, 8'h55)) begin n_err++; $display("FAIL vram_write_1: got %h want %h", obs_q[1], ev_vw(14'h0001, 8'h55)); end
    end
    n_vec++;
    if (cpu_dout !== 8'h55) begin n_err++; $display("FAIL vram_write_dout: got %h want 55", cpu_dout); end
  endtask

  task automatic test_read_ahead();
    do_reset();
    poke(14'h1234, 8'h11); poke(14'h1235, 8'h22);
    op(K_CW, 8'h34);
    @(posedge clk); #1 cpu_din = 8'h12; ctrl_wr = 1'b1;
    @(posedge clk); #1 ctrl_wr = 1'b0;
    n_vec += 3;
    if (busy !== 1'b1)         begin n_err++; $display("FAIL ra_busy_c1: got %b want 1", busy); end
    if (vram_re !== 1'b1)      begin n_err++; $display("FAIL ra_re_c1: got %b want 1", vram_re); end
    if (vram_addr !== 14'h1234) begin n_err++; $display("FAIL ra_addr_c1: got %h want 1234", vram_addr); end
    @(posedge clk); #1;
    n_vec += 2;
    if (busy !== 1'b1)    begin n_err++; $display("FAIL ra_busy_c2: got %b want 1", busy); end
    if (vram_re !== 1'b0) begin n_err++; $display("FAIL ra_re_c2: got %b want 0", vram_re); end
    @(posedge clk); #1;
    n_vec += 2;
    if (busy !== 1'b0)      begin n_err++; $display("FAIL ra_busy_done: got %b want 0", busy); end
    if (cpu_dout !== 8'h11) begin n_err++; $display("FAIL ra_first_byte: got %h want 11", cpu_dout); end
    model_apply(K_CW, 8'h12);
    op(K_DR, 8'h00);
    n_vec++;
    if (cpu_dout !== 8'h22) begin n_err++; $display("FAIL ra_second_byte: got %h want 22", cpu_dout); end
    op(K_DW, 8'h77);
    n_vec++;
    if (obs_q.size() != 3 || obs_q[obs_q.size()-1] !== ev_vw(14'h1236, 8'h77)) begin
      n_err++; $display("FAIL ra_next_addr: got %0d events last %h want write %h", obs_q.size(),
                        obs_q.size() > 0 ? obs_q[obs_q.size()-1] : 32'h0, ev_vw(14'h1236, 8'h77));
    end
  endtask

  task automatic test_reg_write();
    do_reset();
    op(K_CW, 8'hFF); op(K_CW, 8'h81);
    n_vec++;
    if (obs_q.size() != 1 || obs_q[0] !== ev_rw(4'h1, 8'hFF)) begin
      n_err++; $display("FAIL reg_write: got %0d events first %h want only %h", obs_q.size(),
                        obs_q.size() > 0 ? obs_q[0] : 32'h0, ev_rw(4'h1, 8'hFF));
    end
  endtask

  task automatic test_cram_write();
    logic [31:0] want;
    do_reset();
`ifdef GG_CRAM_EN
    op(K_CW, 8'h02); op(K_CW, 8'hC0); op(K_DW, 8'h0F); op(K_DW, 8'h05);
    want = ev_cw(5'd1, 12'h50F);
`else
    op(K_CW, 8'h03); op(K_CW, 8'hC0); op(K_DW, 8'h3F);
    want = ev_cw(5'd3, 12'h03F);
`endif
    n_vec++;
    if (obs_q.size() != 1 || obs_q[0] !== want) begin
      n_err++; $display("FAIL cram_write: got %0d events first %h want only %h", obs_q.size(),
                        obs_q.size() > 0 ? obs_q[0] : 32'h0, want);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    op(K_CW, 8'hFF); op(K_CW, 8'h7F); op(K_DW, 8'h01); op(K_DW, 8'h02);
`ifndef GG_CRAM_EN
    op(K_CW, 8'h1F); op(K_CW, 8'hC0); op(K_DW, 8'h11); op(K_DW, 8'h22);
`endif
    n_vec++;
    if (obs_q.size() < 2 || obs_q[0] !== ev_vw(14'h3FFF, 8'h01) || obs_q[1] !== ev_vw(14'h0000, 8'h02)) begin
      n_err++; $display("FAIL vram_wrap: got %0d events want writes at 3FFF then 0000", obs_q.size());
    end
`ifndef GG_CRAM_EN
    n_vec++;
    if (obs_q.size() != 4 || obs_q[2] !== ev_cw(5'd31, 12'h011) || obs_q[3] !== ev_cw(5'd0, 12'h022)) begin
      n_err++; $display("FAIL cram_wrap: got %0d events want CRAM writes at 31 then 0", obs_q.size());
    end
`endif
  endtask

  task automatic test_status_latch();
    do_reset();
    op(K_CW, 8'h10); op(K_CR, 8'h00); op(K_CW, 8'h20); op(K_CW, 8'h40); op(K_DW, 8'h99);
    n_vec++;
    if (obs_q.size() != 2 || obs_q[0] !== ev_st() || obs_q[1] !== ev_vw(14'h0020, 8'h99)) begin
      n_err++; $display("FAIL status_latch: got %0d events want one status pulse then write at 0020", obs_q.size());
    end
  endtask

  task automatic test_busy_ignore();
    do_reset();
    poke(14'h0000, 8'h6B);
    op(K_CW, 8'h00);
    @(posedge clk); #1 cpu_din = 8'h00; ctrl_wr = 1'b1;
    @(posedge clk); #1 ctrl_wr = 1'b0; cpu_din = 8'hEE; data_wr = 1'b1;
    @(posedge clk); #1 data_wr = 1'b0; data_rd = 1'b1;
    @(posedge clk); #1 data_rd = 1'b0;
    model_apply(K_CW, 8'h00);
    n_vec += 3;
    if (busy !== 1'b0)      begin n_err++; $display("FAIL busy_ign_busy: got %b want 0", busy); end
    if (cpu_dout !== 8'h6B) begin n_err++; $display("FAIL busy_ign_dout: got %h want 6b", cpu_dout); end
    if (obs_q.size() != 1 || obs_q[0] !== ev_re(14'h0000)) begin
      n_err++; $display("FAIL busy_ign_events: got %0d events want single fetch at 0000", obs_q.size());
    end
    repeat (2) @(posedge clk);
    op(K_DW, 8'h5A);
    n_vec++;
    if (obs_q.size() != 2 || obs_q[1] !== ev_vw(14'h0001, 8'h5A)) begin
      n_err++; $display("FAIL busy_ign_addr: got %0d events want write at 0001", obs_q.size());
    end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    poke(14'h0000, 8'hC3);
    op(K_CW, 8'h00);
    @(posedge clk); #1 cpu_din = 8'h00; ctrl_wr = 1'b1;
    @(posedge clk); #1 ctrl_wr = 1'b0; reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    n_vec += 2;
    if (busy !== 1'b0)      begin n_err++; $display("FAIL rst_fetch_busy: got %b want 0", busy); end
    if (cpu_dout !== 8'h00) begin n_err++; $display("FAIL rst_fetch_dout: got %h want 00", cpu_dout); end
    repeat (3) @(posedge clk);
    #1;
    n_vec += 2;
    if (cpu_dout !== 8'h00) begin n_err++; $display("FAIL rst_fetch_dout_late: got %h want 00", cpu_dout); end
    if (obs_q.size() != 1)  begin n_err++; $display("FAIL rst_fetch_re: got %0d events want 1", obs_q.size()); end
  endtask

  task automatic test_random();
    int kind;
    logic [7:0] d;
    do_reset();
    @(posedge clk); #1 fill_req = 1'b1;
    @(posedge clk); #1 fill_req = 1'b0;
    for (int i = 0; i < 16384; i++) ref_mem[i] = fill_val(i);
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 3);
      d = 8'($urandom_range(0, 255));
      op(kind, d);
      n_vec += 2;
      if (cpu_dout !== ref_buf) begin n_err++; $display("FAIL rand_dout[%0d]: got %h want %h", n, cpu_dout, ref_buf); end
      if (obs_q.size() != exp_q.size()) begin
        n_err++; $display("FAIL rand_event_count[%0d]: got %0d want %0d", n, obs_q.size(), exp_q.size());
      end else begin
        for (int k = 0; k < exp_q.size(); k++) begin
          n_vec++;
          if (obs_q[k] !== exp_q[k]) begin n_err++; $display("FAIL rand_event[%0d]: got %h want %h", n, obs_q[k], exp_q[k]); end
        end
      end
      obs_q.delete();
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_vram_write();
    test_read_ahead();
    test_reg_write();
    test_cram_write();
    test_wrap();
    test_status_latch();
    test_busy_ignore();
    test_reset_mid_fetch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
